// File: rtl/sample_delay_pkg.sv
// Shared types and sizing helpers for the sample delay reader.
package sample_delay_pkg;

  // Output mode of the reader: delayed tap (IDLE) or direct pass-through (BURST).
  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } rd_state_t;

  // Width of the burst sample counter; bounds BURST_LEN to 1..1023.
  localparam int CNT_W = 10;

  // Number of ring entries for a given address width.
  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/sample_ram.sv
// Simple dual-port ring storage: one write port, one registered read port.
// No reset, so the array maps onto block RAM rather than flops.
module sample_ram
  import sample_delay_pkg::*;
#(
  parameter int BIT_WIDTH = 32,
  parameter int ADDR_W    = 6
) (
  input  logic                 a_clk,
  input  logic                 we,
  input  logic [ADDR_W-1:0]    wa,
  input  logic [BIT_WIDTH-1:0] wd,
  input  logic [ADDR_W-1:0]    ra,
  output logic [BIT_WIDTH-1:0] rd_data
);

  localparam int DEPTH = depth_of(ADDR_W);

  logic [BIT_WIDTH-1:0] mem [DEPTH];

  // Write the new sample and register the read; a same-address read returns old data.
  always_ff @(posedge a_clk) begin
    if (we) begin
      mem[wa] <= wd;
    end
    rd_data <= mem[ra];
  end

endmodule

// File: rtl/sample_delay_reader.sv
// Ring-buffer delay tap with a triggered burst of direct (undelayed) samples.
// Pipeline: stage 1 latches the in_valid cycle, stage 2 is the RAM read,
// stage 3 registers q, giving q_valid two cycles after in_valid.
module sample_delay_reader
  import sample_delay_pkg::*;
#(
  parameter int BIT_WIDTH = 32,
  parameter int ADDR_W    = 6,
  parameter int BURST_LEN = 64
) (
  input  logic                        a_clk,
  input  logic                        reset_n,
  input  logic                        in_valid,
  input  logic signed [BIT_WIDTH-1:0] d_in,
  input  logic [ADDR_W-1:0]           delay,
  input  logic                        trig,
  output logic signed [BIT_WIDTH-1:0] q,
  output logic                        q_valid,
  output logic                        busy
);

  localparam int                FILL_W     = ADDR_W + 1;
  localparam logic [FILL_W-1:0] FILL_MAX   = FILL_W'(depth_of(ADDR_W));
  localparam logic [CNT_W-1:0]  BURST_LAST = CNT_W'(BURST_LEN);

  logic [ADDR_W-1:0]           wp_reg;
  logic [ADDR_W-1:0]           ra;
  logic [FILL_W-1:0]           fill_reg;
  logic [FILL_W-1:0]           fill_next;
  logic [BIT_WIDTH-1:0]        rd_data;

  rd_state_t                   state_reg, state_next;
  logic [CNT_W-1:0]            cnt_reg, cnt_next;

  logic                        s1_valid_reg;
  logic [ADDR_W-1:0]           s1_delay_reg;
  logic signed [BIT_WIDTH-1:0] s1_data_reg;
  logic                        s1_burst_reg;
  logic [FILL_W-1:0]           s1_fill_reg;

  logic signed [BIT_WIDTH-1:0] q_sel;
  logic signed [BIT_WIDTH-1:0] q_reg;
  logic                        q_valid_reg;

  // Read address uses the pre-increment write pointer, so delay 0 names this sample.
  assign ra = wp_reg - delay;

  // Samples held after this write, saturating once the ring is full.
  assign fill_next = (fill_reg == FILL_MAX) ? FILL_MAX : fill_reg + 1'b1;

  // Write pointer and fill level advance once per accepted sample.
  always_ff @(posedge a_clk) begin
    if (reset_n) begin
      wp_reg   <= '0;
      fill_reg <= '0;
    end else if (in_valid) begin
      wp_reg   <= wp_reg + 1'b1;
      fill_reg <= fill_next;
    end
  end

  sample_ram #(
    .BIT_WIDTH(BIT_WIDTH),
    .ADDR_W   (ADDR_W)
  ) u_ram (
    .a_clk  (a_clk),
    .we     (in_valid & ~reset_n),
    .wa     (wp_reg),
    .wd     (d_in),
    .ra     (ra),
    .rd_data(rd_data)
  );

  // FSM state and burst counter registers.
  always_ff @(posedge a_clk) begin
    if (reset_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next state: a trigger only takes effect from IDLE; the burst ends on its last sample.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (trig) begin
          state_next = BURST;
          cnt_next   = '0;
        end
      end
      BURST: begin
        if (in_valid) begin
          cnt_next = cnt_reg + 1'b1;
          if (cnt_reg + 1'b1 == BURST_LAST) begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Stage 1: capture per-sample context alongside the RAM read request.
  always_ff @(posedge a_clk) begin
    if (reset_n) begin
      s1_valid_reg <= 1'b0;
      s1_delay_reg <= '0;
      s1_data_reg  <= '0;
      s1_burst_reg <= 1'b0;
      s1_fill_reg  <= '0;
    end else begin
      s1_valid_reg <= in_valid;
      if (in_valid) begin
        s1_delay_reg <= delay;
        s1_data_reg  <= d_in;
        s1_burst_reg <= (state_reg == BURST);
        s1_fill_reg  <= fill_next;
      end
    end
  end

  // Output select: direct in burst, zero for a tap older than anything written,
  // the current sample for delay 0 (the RAM returns pre-write data), else RAM.
  always_comb begin
    q_sel = rd_data;
    if (s1_burst_reg) begin
      q_sel = s1_data_reg;
    end else if ({1'b0, s1_delay_reg} >= s1_fill_reg) begin
      q_sel = '0;
    end else if (s1_delay_reg == '0) begin
      q_sel = s1_data_reg;
    end
  end

  // Stage 3: q updates only on a valid sample and holds otherwise.
  always_ff @(posedge a_clk) begin
    if (reset_n) begin
      q_reg       <= '0;
      q_valid_reg <= 1'b0;
    end else begin
      q_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        q_reg <= q_sel;
      end
    end
  end

  assign q       = q_reg;
  assign q_valid = q_valid_reg;
  assign busy    = (state_reg == BURST);

endmodule

// File: tb/tb_sample_delay_reader.sv
// Directed bench for sample_delay_reader: tap, fill guard, wrap, burst, reset.
module tb_sample_delay_reader;

  logic               a_clk;
  logic               reset_n;
  logic               in_valid;
  logic signed [31:0] d_in;
  logic [5:0]         delay;
  logic               trig;
  logic signed [31:0] q;
  logic               q_valid;
  logic               busy;

  int tests_run    = 0;
  int tests_failed = 0;

  // Expectation for the sample driven on the previous call, and the held q value.
  logic               prev_v;
  logic signed [31:0] prev_q;
  logic signed [31:0] last_q;

  sample_delay_reader #(
    .BIT_WIDTH(32),
    .ADDR_W   (6),
    .BURST_LEN(64)
  ) dut (
    .a_clk   (a_clk),
    .reset_n (reset_n),
    .in_valid(in_valid),
    .d_in    (d_in),
    .delay   (delay),
    .trig    (trig),
    .q       (q),
    .q_valid (q_valid),
    .busy    (busy)
  );

  initial a_clk = 1'b0;
  always #5 a_clk = ~a_clk;

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock with the given inputs; checks the output of the previous sample,
  // the held q when nothing was valid, and busy after this edge.
  task automatic cycle(input logic v, input int d, input logic tr, input logic [5:0] dly,
                       input int exp_q, input logic exp_busy);
    in_valid = v;
    d_in     = d;
    trig     = tr;
    delay    = dly;
    @(posedge a_clk);
    #1;
    $display("[TB] t=%0t in_valid=%0b d_in=%0d trig=%0b q_valid=%0b q=%0d busy=%0b",
             $time, v, d, tr, q_valid, q, busy);
    check("q_valid", {31'd0, q_valid}, {31'd0, prev_v});
    if (prev_v) begin
      check("q", q, prev_q);
      last_q = prev_q;
    end else begin
      check("q_hold", q, last_q);
    end
    check("busy", {31'd0, busy}, {31'd0, exp_busy});
    prev_v = v;
    prev_q = exp_q;
  endtask

  // One reset cycle (optionally with a sample offered, which must be dropped).
  task automatic do_reset(input logic v, input int d);
    reset_n  = 1'b1;
    in_valid = v;
    d_in     = d;
    trig     = 1'b0;
    @(posedge a_clk);
    #1;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    $display("[TB] t=%0t reset q_valid=%0b q=%0d busy=%0b", $time, q_valid, q, busy);
    check("rst_q_valid", {31'd0, q_valid}, 32'd0);
    check("rst_q", q, 32'sd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    prev_v = 1'b0;
    prev_q = 0;
    last_q = 0;
  endtask

  task automatic flush();
    for (int i = 0; i < 3; i++) cycle(1'b0, 0, 1'b0, 6'd0, 0, 1'b0);
  endtask

  initial begin
    reset_n  = 1'b1;
    in_valid = 1'b0;
    d_in     = 0;
    delay    = '0;
    trig     = 1'b0;
    prev_v   = 1'b0;
    prev_q   = 0;
    last_q   = 0;
    @(posedge a_clk);
    do_reset(1'b0, 0);

    // Basic tap: delay 3, d_in = 1..10 -> q = 0,0,0,1..7.
    for (int i = 0; i < 10; i++)
      cycle(1'b1, i + 1, 1'b0, 6'd3, (i >= 3) ? i - 2 : 0, 1'b0);
    flush();

    // Fill guard: delay 10, only five samples -> all zero.
    do_reset(1'b0, 0);
    for (int i = 0; i < 5; i++)
      cycle(1'b1, -(i + 1), 1'b0, 6'd10, 0, 1'b0);
    flush();

    // Wrap: delay 63 over 200 samples.
    do_reset(1'b0, 0);
    for (int n = 0; n < 200; n++)
      cycle(1'b1, n, 1'b0, 6'd63, (n >= 63) ? n - 63 : 0, 1'b0);
    flush();

    // Burst with trig at 20, retriggers at 40 and on the last burst sample 84.
    do_reset(1'b0, 0);
    for (int n = 0; n < 200; n++)
      cycle(1'b1, n, (n == 20 || n == 40 || n == 84), 6'd5,
            (n >= 21 && n <= 84) ? n : ((n >= 5) ? n - 5 : 0),
            (n >= 20 && n <= 83));
    flush();

    // Reset mid-burst, then restart with delay 2.
    do_reset(1'b0, 0);
    for (int n = 0; n < 50; n++)
      cycle(1'b1, n, (n == 0), 6'd5, (n >= 1) ? n : 0, 1'b1);
    do_reset(1'b1, 50);
    cycle(1'b0, 0, 1'b0, 6'd2, 0, 1'b0);
    cycle(1'b0, 0, 1'b0, 6'd2, 0, 1'b0);
    for (int k = 0; k < 10; k++)
      cycle(1'b1, 100 + k, 1'b0, 6'd2, (k >= 2) ? 98 + k : 0, 1'b0);
    flush();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
